// File: rtl/snake_pkg.sv
// Shared definitions for the snake display scan path: FSM states, pixel
// object codes, grid size and the colour priority encoder.
package snake_pkg;

  localparam int unsigned GRID_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] COLOR_BG     = 3'd0;
  localparam logic [2:0] COLOR_BORDER = 3'd1;
  localparam logic [2:0] COLOR_HEAD   = 3'd2;
  localparam logic [2:0] COLOR_BODY   = 3'd3;
  localparam logic [2:0] COLOR_APPLE  = 3'd4;

  // Border wins over head so a head on the wall is drawn as wall.
  function automatic logic [2:0] pick_color(
    input logic border,
    input logic head,
    input logic body,
    input logic apple
  );
    if (border)     return COLOR_BORDER;
    else if (head)  return COLOR_HEAD;
    else if (body)  return COLOR_BODY;
    else if (apple) return COLOR_APPLE;
    else            return COLOR_BG;
  endfunction

endpackage

// File: rtl/grid_counter.sv
// Raster-order x/y cell counter with clear, advance enable and a flag
// marking the final cell of the grid.
module grid_counter #(
  parameter int unsigned GRID_MAX = 15,
  parameter int unsigned CW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          last
);

  localparam logic [CW-1:0] MAX = CW'(GRID_MAX);

  logic x_end;
  logic y_end;

  assign x_end = (x == MAX);
  assign y_end = (y == MAX);
  assign last  = x_end && y_end;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      x <= '0;
      y <= '0;
    end else if (enable) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + CW'(1);
      end else begin
        x <= x + CW'(1);
      end
    end
  end

endmodule

// File: rtl/grid_scan_controller.sv
// Walks every grid cell once per frame, hands the object code for each cell
// to the display writer and records whether the head collided this frame.
module grid_scan_controller #(
  parameter int unsigned GRID_MAX = snake_pkg::GRID_MAX,
  parameter int unsigned FCNT_W   = 8,
  localparam int unsigned CW      = $clog2(GRID_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [CW-1:0]     x,
  output logic [CW-1:0]     y,
  input  logic              isBorder,
  input  logic              isHead,
  input  logic              isBody,
  input  logic              isApple,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [2:0]        pix_color,
  output logic              busy,
  output logic              frame_done,
  output logic              collision,
  output logic [FCNT_W-1:0] frame_cnt
);

  import snake_pkg::*;

  state_t state;
  state_t state_next;

  logic transfer;
  logic last_cell;
  logic cnt_clear;
  logic hit;

  grid_counter #(
    .GRID_MAX (GRID_MAX),
    .CW       (CW)
  ) u_grid_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (transfer),
    .x      (x),
    .y      (y),
    .last   (last_cell)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_SCAN;
      ST_SCAN: if (transfer && last_cell) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    pix_valid  = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    cnt_clear  = 1'b0;
    unique case (state)
      ST_IDLE: cnt_clear = 1'b1;
      ST_SCAN: begin
        pix_valid = 1'b1;
        busy      = 1'b1;
      end
      ST_DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
      end
      default: cnt_clear = 1'b1;
    endcase
  end

  assign transfer  = pix_valid && pix_ready;
  assign pix_color = pick_color(isBorder, isHead, isBody, isApple);

  // hit from the last transfer is registered before DONE, so DONE sees it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit       <= 1'b0;
      collision <= 1'b0;
      frame_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (start) hit <= 1'b0;
        ST_SCAN: if (transfer && isHead && (isBorder || isBody)) hit <= 1'b1;
        ST_DONE: begin
          collision <= hit;
          frame_cnt <= frame_cnt + FCNT_W'(1);
        end
        default: hit <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_scan_controller.sv
// Directed bench for grid_scan_controller with a behavioural border
// generator and programmable head/body/apple cells.
module tb_grid_scan_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] x;
  logic [3:0] y;
  logic       isBorder;
  logic       isHead;
  logic       isBody;
  logic       isApple;
  logic       pix_valid;
  logic       pix_ready;
  logic [2:0] pix_color;
  logic       busy;
  logic       frame_done;
  logic       collision;
  logic [7:0] frame_cnt;

  logic       head_en, body_en, apple_en;
  logic [3:0] hx, hy, bx, by, ax, ay;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign isBorder = (x == 4'd0) || (x == 4'd15) || (y == 4'd0) || (y == 4'd15);
  assign isHead   = head_en  && (x == hx) && (y == hy);
  assign isBody   = body_en  && (x == bx) && (y == by);
  assign isApple  = apple_en && (x == ax) && (y == ay);

  grid_scan_controller #(
    .GRID_MAX (15),
    .FCNT_W   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .x          (x),
    .y          (y),
    .isBorder   (isBorder),
    .isHead     (isHead),
    .isBody     (isBody),
    .isApple    (isApple),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_color  (pix_color),
    .busy       (busy),
    .frame_done (frame_done),
    .collision  (collision),
    .frame_cnt  (frame_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; pix_ready = 1'b1;
    head_en = 1'b0; body_en = 1'b0; apple_en = 1'b0;
    hx = '0; hy = '0; bx = '0; by = '0; ax = '0; ay = '0;
    tick; tick;
    rst = 1'b0;
    repeat (5) tick;
    tests++; if (x !== 4'd0) begin fails++; $display("FAIL reset_x got %0d want 0", x); end
    tests++; if (y !== 4'd0) begin fails++; $display("FAIL reset_y got %0d want 0", y); end
    tests++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", pix_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", frame_done); end
    tests++; if (collision !== 1'b0) begin fails++; $display("FAIL reset_coll got %b want 0", collision); end
    tests++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL reset_fcnt got %0d want 0", frame_cnt); end
  endtask

  // Full frame: raster order, border colours, DONE 257 cycles after start.
  task automatic test_frame;
    logic [3:0] ex, ey;
    logic [2:0] ec;
    int cyc;
    start = 1'b1; tick; start = 1'b0; cyc = 1;
    for (int i = 0; i < 256; i++) begin
      ex = 4'(i % 16);
      ey = 4'(i / 16);
      ec = (ex == 0 || ex == 15 || ey == 0 || ey == 15) ? 3'd1 : 3'd0;
      tests++; if (pix_valid !== 1'b1 || busy !== 1'b1 || frame_done !== 1'b0) begin
        fails++; $display("FAIL frame_flags cell %0d got v=%b b=%b d=%b want 1 1 0", i, pix_valid, busy, frame_done); end
      tests++; if (x !== ex || y !== ey) begin
        fails++; $display("FAIL frame_xy cell %0d got (%0d,%0d) want (%0d,%0d)", i, x, y, ex, ey); end
      tests++; if (pix_color !== ec) begin
        fails++; $display("FAIL frame_color cell %0d got %0d want %0d", i, pix_color, ec); end
      tick; cyc++;
    end
    tests++; if (frame_done !== 1'b1 || busy !== 1'b1 || pix_valid !== 1'b0) begin
      fails++; $display("FAIL frame_done_at_%0d got d=%b b=%b v=%b want 1 1 0", cyc, frame_done, busy, pix_valid); end
    tick;
    tests++; if (frame_done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL frame_done_pulse got d=%b b=%b want 0 0", frame_done, busy); end
    tests++; if (frame_cnt !== 8'd1) begin fails++; $display("FAIL frame_cnt got %0d want 1", frame_cnt); end
    tests++; if (collision !== 1'b0) begin fails++; $display("FAIL frame_coll got %b want 0", collision); end
  endtask

  // Backpressure at (5,7) with an apple there.
  task automatic test_stall;
    apple_en = 1'b1; ax = 4'd5; ay = 4'd7;
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      tests++; if (x !== 4'(i % 16) || y !== 4'(i / 16)) begin
        fails++; $display("FAIL stall_xy cell %0d got (%0d,%0d) want (%0d,%0d)", i, x, y, i % 16, i / 16); end
      if (i == 117) begin
        pix_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick;
          tests++; if (x !== 4'd5 || y !== 4'd7 || pix_valid !== 1'b1) begin
            fails++; $display("FAIL stall_hold %0d got (%0d,%0d) v=%b want (5,7) v=1", k, x, y, pix_valid); end
          tests++; if (pix_color !== 3'd4) begin
            fails++; $display("FAIL stall_color %0d got %0d want 4", k, pix_color); end
        end
        pix_ready = 1'b1;
      end
      tick;
    end
    tests++; if (frame_done !== 1'b1) begin fails++; $display("FAIL stall_done got %b want 1", frame_done); end
    tick;
    tests++; if (frame_cnt !== 8'd2) begin fails++; $display("FAIL stall_fcnt got %0d want 2", frame_cnt); end
    apple_en = 1'b0;
  endtask

  // Head on the last border cell collides; next clean frame clears it.
  task automatic test_collision;
    head_en = 1'b1; hx = 4'd15; hy = 4'd15;
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        tests++; if (pix_color !== 3'd1) begin fails++; $display("FAIL coll_color got %0d want 1", pix_color); end
      end
      tick;
    end
    tests++; if (frame_done !== 1'b1) begin fails++; $display("FAIL coll_done got %b want 1", frame_done); end
    tick;
    tests++; if (collision !== 1'b1) begin fails++; $display("FAIL coll_set got %b want 1", collision); end
    tests++; if (frame_cnt !== 8'd3) begin fails++; $display("FAIL coll_fcnt got %0d want 3", frame_cnt); end
    head_en = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (i == 100) begin
        tests++; if (collision !== 1'b1) begin fails++; $display("FAIL coll_hold got %b want 1", collision); end
      end
      tick;
    end
    tick;
    tests++; if (collision !== 1'b0) begin fails++; $display("FAIL coll_clear got %b want 0", collision); end
    tests++; if (frame_cnt !== 8'd4) begin fails++; $display("FAIL coll_fcnt2 got %0d want 4", frame_cnt); end
  endtask

  // Head over apple draws head; start during SCAN and DONE is dropped.
  task automatic test_priority_ignore;
    int xfers;
    int cyc;
    head_en = 1'b1; hx = 4'd4; hy = 4'd4;
    apple_en = 1'b1; ax = 4'd4; ay = 4'd4;
    start = 1'b1; tick; start = 1'b0;
    xfers = 0; cyc = 0;
    while (frame_done !== 1'b1 && cyc < 400) begin
      if (pix_valid && x == 4'd4 && y == 4'd4) begin
        tests++; if (pix_color !== 3'd2) begin fails++; $display("FAIL prio_color got %0d want 2", pix_color); end
      end
      start = (cyc == 50);
      if (pix_valid && pix_ready) xfers++;
      tick; cyc++;
    end
    start = 1'b0;
    tests++; if (xfers !== 256) begin fails++; $display("FAIL prio_xfers got %0d want 256 (cycles %0d)", xfers, cyc); end
    start = 1'b1; tick; start = 1'b0;
    tests++; if (busy !== 1'b0 || frame_done !== 1'b0) begin
      fails++; $display("FAIL done_start got b=%b d=%b want 0 0", busy, frame_done); end
    tick;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL done_start_idle got %b want 0", busy); end
    tests++; if (collision !== 1'b0) begin fails++; $display("FAIL prio_coll got %b want 0", collision); end
    tests++; if (frame_cnt !== 8'd5) begin fails++; $display("FAIL prio_fcnt got %0d want 5", frame_cnt); end
    head_en = 1'b0; apple_en = 1'b0;
  endtask

  // Reset at (9,3) aborts the scan without a frame_done pulse.
  task automatic test_reset_midscan;
    logic seen_done;
    start = 1'b1; tick; start = 1'b0;
    repeat (57) tick;
    tests++; if (x !== 4'd9 || y !== 4'd3) begin fails++; $display("FAIL rst_pos got (%0d,%0d) want (9,3)", x, y); end
    rst = 1'b1; tick; rst = 1'b0;
    tests++; if (busy !== 1'b0 || pix_valid !== 1'b0 || frame_done !== 1'b0) begin
      fails++; $display("FAIL rst_flags got b=%b v=%b d=%b want 0 0 0", busy, pix_valid, frame_done); end
    tests++; if (x !== 4'd0 || y !== 4'd0) begin fails++; $display("FAIL rst_xy got (%0d,%0d) want (0,0)", x, y); end
    tests++; if (collision !== 1'b0 || frame_cnt !== 8'd0) begin
      fails++; $display("FAIL rst_state got c=%b f=%0d want 0 0", collision, frame_cnt); end
    seen_done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (frame_done || busy) seen_done = 1'b1;
      tick;
    end
    tests++; if (seen_done !== 1'b0) begin fails++; $display("FAIL rst_no_done got %b want 0", seen_done); end
  endtask

  initial begin
    test_reset;
    test_frame;
    test_stall;
    test_collision;
    test_priority_ignore;
    test_reset_midscan;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/grid_scan_controller.md
GRID_SCAN_CONTROLLER -- requirements
Module: grid_scan_controller

Interface
REQ-001 Parameter GRID_MAX, 15, last cell index on each axis of the 16x16 grid.
REQ-002 Parameter FCNT_W, 8, width of the frame counter.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  frame request, single-cycle pulse.
REQ-006 x  output  4  current cell column, driven to border_generator and the object generators.
REQ-007 y  output  4  current cell row, driven to the generators.
REQ-008 isBorder  input  1  border_generator result for (x,y), same cycle.
REQ-009 isHead  input  1  snake-head generator result for (x,y), same cycle.
REQ-010 isBody  input  1  snake-body generator result for (x,y), same cycle.
REQ-011 isApple  input  1  apple generator result for (x,y), same cycle.
REQ-012 pix_valid  output  1  pix_color is valid for cell (x,y).
REQ-013 pix_ready  input  1  downstream display writer accepts the pixel.
REQ-014 pix_color  output  3  object code for (x,y).
REQ-015 busy  output  1  a scan is in progress.
REQ-016 frame_done  output  1  single-cycle pulse at scan end.
REQ-017 collision  output  1  head hit border or body during the last completed frame.
REQ-018 frame_cnt  output  FCNT_W  count of completed frames.

Function
REQ-019 The FSM SHALL have states IDLE, SCAN and DONE.
REQ-020 In IDLE: x=0, y=0, pix_valid=0, busy=0.
REQ-021 start in IDLE SHALL move the FSM to SCAN on the next edge, with (x,y)=(0,0) and an internal hit flag cleared.
REQ-022 start outside IDLE SHALL be ignored, with no queuing.
REQ-023 In SCAN: pix_valid=1 and busy=1.
REQ-024 A transfer SHALL occur on the cycle pix_valid and pix_ready are both high.
REQ-025 With pix_ready low, x, y and the FSM state SHALL hold.
REQ-026 On a transfer with x<GRID_MAX, x SHALL increment.
REQ-027 On a transfer with x=GRID_MAX, x SHALL wrap to 0 and y SHALL increment (raster order).
REQ-028 A transfer at (GRID_MAX,GRID_MAX) SHALL move the FSM to DONE, with x and y returning to 0.
REQ-029 pix_color SHALL be combinational with fixed priority: border=1 > head=2 > body=3 > apple=4 > background=0.
REQ-030 On each transfer, hit SHALL be set if isHead and (isBorder or isBody).
REQ-031 DONE SHALL last exactly one cycle.
REQ-032 In DONE: frame_done=1, busy=1, pix_valid=0; collision SHALL load hit (including a hit from the final transfer), and frame_cnt SHALL increment with wrap at 2^FCNT_W.
REQ-033 DONE SHALL always return to IDLE; start in DONE is ignored.
REQ-034 A frame SHALL take exactly 256 transfers. With pix_ready held high, start to frame_done is 257 cycles (frame_done is high 257 cycles after the start edge).
REQ-035 collision SHALL hold its value until the next DONE.

Reset
REQ-036 rst SHALL override all other inputs, including mid-scan.
REQ-037 After rst: FSM=IDLE, x=0, y=0, pix_valid=0, busy=0, frame_done=0, collision=0, frame_cnt=0, hit=0.
REQ-038 A scan interrupted by rst SHALL NOT pulse frame_done or update collision.

Structure
REQ-039 Package snake_pkg SHALL hold the FSM state enum, the pix_color codes and the GRID_MAX constant.
REQ-040 Sub-module grid_counter SHALL contain the x/y raster counter (enable, wrap, last-cell flag).
REQ-041 border_generator SHALL remain external, connected via x, y and isBorder.

Verification
REQ-042 Reset then idle 5 cycles -> x=y=0, pix_valid=0, busy=0, frame_cnt=0.
REQ-043 start with pix_ready=1 and border_generator attached -> 256 pixels in raster order; color=1 exactly where x or y is 0 or 15; frame_done at cycle 257; frame_cnt=1.
REQ-044 pix_ready low for 3 cycles at (5,7) -> x=5, y=7 and pix_color held; no skipped or duplicated cell.
REQ-045 isHead asserted only at (15,15) -> pix_color=1, collision=1 after DONE. Next frame with no head -> collision=0.
REQ-046 isHead and isApple at (4,4) -> pix_color=2. start pulsed during SCAN -> ignored, total 256 transfers.
REQ-047 rst at (9,3) mid-scan -> IDLE next cycle, no frame_done, collision and frame_cnt unchanged from reset values.
